prog_loader: RTL
================

PROG_LOADER -- requirements
Module: prog_loader

Interface
REQ-001 Parameter ADDR_BASE, default 32'h0000_0000, byte address of the first loaded word; SHALL be a multiple of 4.
REQ-002 Parameter MAX_WORDS, default 1024, largest accepted word count.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 rx_data  input  8  incoming program byte.
REQ-006 rx_valid  input  1  rx_data valid this cycle.
REQ-007 rx_ready  output  1  loader accepts a byte this cycle.
REQ-008 cpu_en  output  1  bus ownership; 0 = loader drives memory bus, 1 = core runs, loader at hi-Z.
REQ-009 mem_we  output  1  memory write strobe; hi-Z when cpu_en=1.
REQ-010 mem_addr  output  32  memory byte address; hi-Z when cpu_en=1.
REQ-011 mem_data  inout  32  write data; driven only when cpu_en=0 and mem_we=1, else hi-Z; never sampled.
REQ-012 busy  output  1  loading in progress (states HDR, DATA, WRITE, CSUM).
REQ-013 err  output  1  sticky load-failure flag.

Function
REQ-014 Byte handshake: a byte is consumed on a rising edge where rx_valid=1 and rx_ready=1; rx_ready is 1 only in HDR, DATA, CSUM.
REQ-015 Stream format: 4-byte word count N (first byte = N[31:24]), then N words of 4 bytes, then (with LOADER_CHECKSUM_EN defined) one checksum byte.
REQ-016 States: HDR -> DATA -> WRITE -> (DATA | CSUM | RUN); ERR and RUN are terminal until rst.
REQ-017 HDR: after the 4th byte, N=0 -> CSUM (macro defined) or RUN; N>MAX_WORDS -> ERR; otherwise -> DATA.
REQ-018 DATA: after the 4th byte of word i -> WRITE; bytes b0..b3 in arrival order are placed as mem_data = {b3,b2,b1,b0}, i.e. b0 on bits [7:0], matching the core's byte-swapped word view.
REQ-019 WRITE: exactly one cycle with mem_we=1, mem_addr = ADDR_BASE + 4*i, mem_data per REQ-018; then i increments; i=N -> CSUM/RUN, else -> DATA.
REQ-020 Outside WRITE with cpu_en=0: mem_we=0, mem_addr=ADDR_BASE, mem_data hi-Z.
REQ-021 Word index i and address arithmetic are 32-bit, unsigned; no wrap is possible because N<=MAX_WORDS.
REQ-022 RUN: cpu_en=1 from the first cycle in RUN onward; rx_ready=0; further rx_valid is ignored.
REQ-023 ERR: cpu_en=0, err=1, rx_ready=0, mem_we=0; bus remains driven by loader so the core never starts.
REQ-024 rx_valid held low mid-word or mid-header: loader waits indefinitely, no timeout, partial bytes retained.
REQ-025 Minimum latency: last data byte accepted at edge k -> mem_we=1 in cycle k+1 -> cpu_en=1 at edge k+2 (macro undefined).

Reset
REQ-026 On rst=1, asynchronously: state=HDR, i=0, byte counter=0, N=0, checksum accumulator=0, cpu_en=0, mem_we=0, err=0, busy=1, rx_ready=1 once rst deasserts.
REQ-027 rst asserted mid-load or in RUN/ERR aborts immediately; cpu_en drops to 0 asynchronously, and memory contents already written are not cleared.

Configuration
REQ-028 Macro LOADER_CHECKSUM_EN: defined -> state CSUM present, accumulator XORs every accepted header and data byte; trailing byte equal to accumulator -> RUN, unequal -> ERR.
REQ-029 Macro undefined: no CSUM state or accumulator; last WRITE (or N=0 header) goes straight to RUN, and err is set only by N>MAX_WORDS.

Verification
REQ-030 Bytes 00 00 00 01 | 11 22 33 44 (no macro) -> one write, mem_addr=0x0, mem_data=0x44332211, then cpu_en=1, buses hi-Z.
REQ-031 N=3, ADDR_BASE=0x100 -> writes at 0x100, 0x104, 0x108, each mem_we pulse exactly 1 cycle.
REQ-032 Header 00 00 04 01 with MAX_WORDS=1024 -> err=1, cpu_en=0, rx_ready=0 permanently.
REQ-033 Macro defined, N=1, data 01 02 03 04, checksum 0x05 -> cpu_en=1; checksum 0x06 -> err=1, cpu_en=0.
REQ-034 rx_valid toggled randomly with gaps of 0-5 cycles -> identical memory image to back-to-back stream.
REQ-035 rst pulsed after 2 data bytes -> cpu_en=0, state HDR; fresh stream then loads correctly from ADDR_BASE.

Source files
------------

// File: rtl/prog_loader.sv
// prog_loader: receives a length-prefixed byte stream, writes it to memory as 32-bit words,
// then releases the bus to the core. Define LOADER_CHECKSUM_EN to require a trailing XOR checksum byte.
module prog_loader #(
    parameter logic [31:0] ADDR_BASE = 32'h0000_0000,
    parameter int unsigned MAX_WORDS = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    output logic        cpu_en,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    inout  wire  [31:0] mem_data,
    output logic        busy,
    output logic        err
);

    localparam logic [31:0] MAX_W = 32'(MAX_WORDS);

`ifdef LOADER_CHECKSUM_EN
    typedef enum logic [2:0] {S_HDR, S_DATA, S_WRITE, S_CSUM, S_RUN, S_ERR} state_t;
    localparam state_t S_TAIL = S_CSUM;
`else
    typedef enum logic [2:0] {S_HDR, S_DATA, S_WRITE, S_RUN, S_ERR} state_t;
    localparam state_t S_TAIL = S_RUN;
`endif

    state_t      state_q, state_d;
    logic [1:0]  bcnt_q, bcnt_d;
    logic [31:0] nwords_q, nwords_d;
    logic [31:0] idx_q, idx_d;
    logic [31:0] word_q, word_d;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]  csum_q, csum_d;
`endif

    logic        accept;
    logic        we_int;
    logic [31:0] addr_int;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_HDR;
            bcnt_q   <= '0;
            nwords_q <= '0;
            idx_q    <= '0;
            word_q   <= '0;
`ifdef LOADER_CHECKSUM_EN
            csum_q   <= '0;
`endif
        end else begin
            state_q  <= state_d;
            bcnt_q   <= bcnt_d;
            nwords_q <= nwords_d;
            idx_q    <= idx_d;
            word_q   <= word_d;
`ifdef LOADER_CHECKSUM_EN
            csum_q   <= csum_d;
`endif
        end
    end

    always_comb begin
        rx_ready = 1'b0;
        busy     = 1'b0;
        err      = 1'b0;
        cpu_en   = 1'b0;
        we_int   = 1'b0;
        addr_int = ADDR_BASE;
        case (state_q)
            S_HDR, S_DATA: begin
                rx_ready = 1'b1;
                busy     = 1'b1;
            end
`ifdef LOADER_CHECKSUM_EN
            S_CSUM: begin
                rx_ready = 1'b1;
                busy     = 1'b1;
            end
`endif
            S_WRITE: begin
                busy     = 1'b1;
                we_int   = 1'b1;
                addr_int = ADDR_BASE + (idx_q << 2);
            end
            S_RUN:   cpu_en = 1'b1;
            S_ERR:   err    = 1'b1;
            default: ;
        endcase
    end

    assign accept = rx_valid && rx_ready;

    always_comb begin
        state_d  = state_q;
        bcnt_d   = bcnt_q;
        nwords_d = nwords_q;
        idx_d    = idx_q;
        word_d   = word_q;
`ifdef LOADER_CHECKSUM_EN
        csum_d   = csum_q;
`endif
        case (state_q)
            S_HDR: begin
                if (accept) begin
                    bcnt_d   = bcnt_q + 2'd1;
                    nwords_d = {nwords_q[23:0], rx_data};
`ifdef LOADER_CHECKSUM_EN
                    csum_d   = csum_q ^ rx_data;
`endif
                    if (bcnt_q == 2'd3) begin
                        if (nwords_d == '0)
                            state_d = S_TAIL;
                        else if (nwords_d > MAX_W)
                            state_d = S_ERR;
                        else
                            state_d = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (accept) begin
                    // Shift in from the top so the first byte ends up on bits [7:0].
                    word_d = {rx_data, word_q[31:8]};
                    bcnt_d = bcnt_q + 2'd1;
`ifdef LOADER_CHECKSUM_EN
                    csum_d = csum_q ^ rx_data;
`endif
                    if (bcnt_q == 2'd3)
                        state_d = S_WRITE;
                end
            end
            S_WRITE: begin
                idx_d = idx_q + 32'd1;
                if (idx_d == nwords_q)
                    state_d = S_TAIL;
                else
                    state_d = S_DATA;
            end
`ifdef LOADER_CHECKSUM_EN
            S_CSUM: begin
                if (accept)
                    state_d = (rx_data == csum_q) ? S_RUN : S_ERR;
            end
`endif
            default: ;
        endcase
    end

    // Bus is released entirely once the core owns it.
    assign mem_we   = cpu_en ? 1'bz : we_int;
    assign mem_addr = cpu_en ? 'z : addr_int;
    assign mem_data = (!cpu_en && we_int) ? word_q : 'z;

endmodule
